// File: rtl/elink_rx_word_aligner_pkg.sv
// elink_rx_word_aligner_pkg: K28.5 symbols, FSM encodings and default thresholds for the e-link word aligner.
package elink_rx_word_aligner_pkg;

    localparam logic [9:0] K28N = 10'b0011111010;
    localparam logic [9:0] K28P = 10'b1100000101;

    localparam int LOCK_COUNT_DEF = 4;
    localparam int MAX_ERR_DEF    = 3;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    function automatic logic is_k285(input logic [9:0] w);
        return (w == K28N) || (w == K28P);
    endfunction

endpackage

// File: rtl/elink_rx_word_aligner_comma_detect.sv
// elink_comma_detect: flags K28.5 in the even (win[9:0]) and odd (win[10:1]) candidate windows.
module elink_comma_detect
    import elink_rx_word_aligner_pkg::*;
(
    input  logic [10:0] win,
    output logic        hit_w0,
    output logic        hit_w1
);

    assign hit_w0 = is_k285(win[9:0]);
    assign hit_w1 = is_k285(win[10:1]);

endmodule

// File: rtl/elink_rx_word_aligner.sv
// elink_rx_word_aligner: recovers 10-bit 8b10b symbol boundaries from a 2-bit e-link stream using K28.5 commas.
module elink_rx_word_aligner
    import elink_rx_word_aligner_pkg::*;
#(
    parameter int LOCK_COUNT = LOCK_COUNT_DEF,
    parameter int MAX_ERR    = MAX_ERR_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] rx_elink2bit,
    output logic [9:0] word_out,
    output logic       word_valid,
    output logic       is_comma,
    output logic       locked,
    output logic [7:0] realign_cnt
);

    logic [19:0] sr_q, sr_d;
    state_t      state_q, state_d;
    logic        offset_q, offset_d;
    logic [2:0]  phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  err_q, err_d;
    logic [7:0]  realign_q, realign_d;
    logic [9:0]  word_q, word_d;
    logic        valid_q, valid_d;
    logic        comma_q, comma_d;

    logic        hit_w0, hit_w1;
    logic        boundary, sel_hit, aligned, misaligned;
    logic [9:0]  sel_win;
    logic        unused_sr;

    assign unused_sr = ^sr_q[19:18];

    elink_comma_detect u_comma_detect (
        .win    (sr_q[10:0]),
        .hit_w0 (hit_w0),
        .hit_w1 (hit_w1)
    );

    always_comb begin
        boundary   = (phase_q == 3'd4);
        sel_win    = offset_q ? sr_q[10:1] : sr_q[9:0];
        sel_hit    = offset_q ? hit_w1 : hit_w0;
        aligned    = boundary && sel_hit;
        misaligned = (hit_w0 || hit_w1) && !aligned;
        sr_d       = sr_q;
        state_d    = state_q;
        offset_d   = offset_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        realign_d  = realign_q;
        word_d     = word_q;
        valid_d    = valid_q;
        comma_d    = comma_q;
        if (en) begin
            sr_d    = {sr_q[17:0], rx_elink2bit[1], rx_elink2bit[0]};
            phase_d = boundary ? 3'd0 : phase_q + 3'd1;
            valid_d = 1'b0;
            case (state_q)
                ST_SEARCH: begin
                    if (hit_w0 || hit_w1) begin
                        offset_d = !hit_w0;
                        phase_d  = 3'd0;
                        cnt_d    = 8'd1;
                        state_d  = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (boundary) begin
                        if (sel_hit) begin
                            cnt_d = cnt_q + 8'd1;
                            if (cnt_d >= 8'(LOCK_COUNT))
                                state_d = ST_LOCKED;
                        end else begin
                            state_d = ST_SEARCH;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (boundary) begin
                        word_d  = sel_win;
                        valid_d = 1'b1;
                        comma_d = sel_hit;
                    end
                    // a boundary word is still emitted in the cycle that trips the error limit
                    if (aligned) begin
                        err_d = 8'd0;
                    end else if (misaligned) begin
                        err_d = err_q + 8'd1;
                        if (err_d >= 8'(MAX_ERR)) begin
                            err_d     = 8'd0;
                            state_d   = ST_SEARCH;
                            realign_d = (realign_q == 8'hFF) ? realign_q : realign_q + 8'd1;
                        end
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_q      <= '0;
            state_q   <= ST_SEARCH;
            offset_q  <= 1'b0;
            phase_q   <= 3'd0;
            cnt_q     <= 8'd0;
            err_q     <= 8'd0;
            realign_q <= 8'd0;
            word_q    <= 10'd0;
            valid_q   <= 1'b0;
            comma_q   <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            state_q   <= state_d;
            offset_q  <= offset_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            realign_q <= realign_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            comma_q   <= comma_d;
        end
    end

    // a strobe pending across an en-low gap is presented once en returns
    assign word_out    = word_q;
    assign word_valid  = valid_q && en;
    assign is_comma    = comma_q;
    assign locked      = (state_q == ST_LOCKED);
    assign realign_cnt = realign_q;

endmodule

// File: tb/tb_elink_rx_word_aligner.sv
// tb_elink_rx_word_aligner: bit-stream reference model compared against the aligner every cycle.
module tb_elink_rx_word_aligner;

    localparam logic [9:0] KN   = 10'b0011111010;
    localparam logic [9:0] KP   = 10'b1100000101;
    localparam logic [9:0] D215 = 10'b1010101010;
    localparam int LC = 4;
    localparam int ME = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic [1:0] rx = 2'b00;
    logic [9:0] word_out;
    logic       word_valid, is_comma, locked;
    logic [7:0] realign_cnt;

    int checks = 0;
    int failures = 0;

    bit txq[$];
    bit hist[$];
    bit rd;

    int         m_mode, m_off, m_age, m_cnt, m_err, m_realign;
    logic [9:0] m_word;
    bit         m_vq, m_isc;

    elink_rx_word_aligner #(.LOCK_COUNT(LC), .MAX_ERR(ME)) dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .rx_elink2bit (rx),
        .word_out     (word_out),
        .word_valid   (word_valid),
        .is_comma     (is_comma),
        .locked       (locked),
        .realign_cnt  (realign_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] mwin(input int off);
        logic [9:0] w;
        int n = hist.size();
        for (int i = 0; i < 10; i++) w[9-i] = hist[n-10-off+i];
        return w;
    endfunction

    function automatic bit kc(input logic [9:0] w);
        return (w == KN) || (w == KP);
    endfunction

    function automatic logic [20:0] obs();
        return {word_out, word_valid, is_comma, locked, realign_cnt};
    endfunction

    function automatic logic [20:0] expv();
        return {m_word, m_vq & en, m_isc, m_mode == 2, 8'(m_realign)};
    endfunction

    // Reference: windows taken from the received-bit history, word slots every 5 enabled cycles from the anchor comma.
    task automatic model(input bit r, input bit e, input logic [1:0] d);
        logic [9:0] w0, w1;
        bit c0, c1, bnd, sel;
        if (!r) begin
            hist.delete();
            repeat (20) hist.push_back(1'b0);
            m_mode = 0; m_off = 0; m_age = 0; m_cnt = 0; m_err = 0; m_realign = 0;
            m_word = 10'd0; m_vq = 0; m_isc = 0;
            return;
        end
        if (!e) return;
        w0 = mwin(0);
        w1 = mwin(1);
        c0 = kc(w0);
        c1 = kc(w1);
        bnd = (m_age % 5) == 4;
        sel = m_off ? c1 : c0;
        m_vq = 0;
        m_age++;
        if (m_mode == 0) begin
            if (c0 || c1) begin
                m_off = c0 ? 0 : 1;
                m_cnt = 1;
                m_mode = 1;
                m_age = 0;
            end
        end else if (m_mode == 1) begin
            if (bnd) begin
                if (sel) begin
                    m_cnt++;
                    if (m_cnt >= LC) m_mode = 2;
                end else begin
                    m_mode = 0;
                end
            end
        end else begin
            if (bnd) begin
                m_word = m_off ? w1 : w0;
                m_vq = 1;
                m_isc = sel;
            end
            if (bnd && sel) m_err = 0;
            else if (c0 || c1) begin
                m_err++;
                if (m_err >= ME) begin
                    m_err = 0;
                    m_mode = 0;
                    if (m_realign < 255) m_realign++;
                end
            end
        end
        hist.push_back(d[1]);
        hist.push_back(d[0]);
        while (hist.size() > 40) hist.delete(0);
    endtask

    task automatic tick(input bit r, input bit e);
        logic [1:0] d = 2'b00;
        if ((e || !r) && txq.size() > 0) d[1] = txq.pop_front();
        if ((e || !r) && txq.size() > 0) d[0] = txq.pop_front();
        reset = r;
        en = e;
        rx = d;
        model(r, e, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) txq.push_back(w[i]);
    endtask

    task automatic push_k(input int n);
        repeat (n) begin
            push_word(rd ? KP : KN);
            rd = ~rd;
        end
    endtask

    task automatic push_zeros(input int n);
        repeat (n) txq.push_back(1'b0);
    endtask

    task automatic do_reset();
        txq.delete();
        rd = 0;
        tick(0, 1);
        tick(0, 1);
    endtask

    task automatic test_reset();
        txq.delete();
        repeat (8) txq.push_back(1'b1);
        tick(0, 1);
        tick(0, 0);
        checks++;
        if (obs() !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=%h", obs(), 21'h0);
        end
        repeat (3) begin
            tick(1, 1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL reset_release t=%0t got=%h exp=%h", $time, obs(), expv());
            end
        end
    endtask

    task automatic test_lock_even();
        int first = -1;
        int nv = 0;
        do_reset();
        push_zeros(10);
        push_k(12);
        for (int i = 0; i < 45; i++) begin
            tick(1, 1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL even_track t=%0t got=%h exp=%h", $time, obs(), expv());
            end
            if (locked === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first - 8 != 17) begin
            failures++;
            $display("FAIL even_lock_latency got=%0d exp=17", first - 8);
        end
        for (int i = 0; i < 25; i++) begin
            tick(1, 1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL even_words t=%0t got=%h exp=%h", $time, obs(), expv());
            end
            if (word_valid === 1'b1) begin
                nv++;
                checks++;
                if (is_comma !== 1'b1 || !kc(word_out)) begin
                    failures++;
                    $display("FAIL even_comma word=%b is_comma=%b exp K28.5 with is_comma=1", word_out, is_comma);
                end
            end
        end
        checks++;
        if (nv != 5) begin
            failures++;
            $display("FAIL even_word_rate got=%0d exp=5", nv);
        end
    endtask

    task automatic test_lock_odd();
        int first = -1;
        int nv = 0;
        logic [9:0] prev = 10'd0;
        do_reset();
        push_zeros(11);
        push_k(13);
        for (int i = 0; i < 45; i++) begin
            tick(1, 1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL odd_track t=%0t got=%h exp=%h", $time, obs(), expv());
            end
            if (locked === 1'b1 && first < 0) first = i;
        end
        checks++;
        if (first - 9 != 17) begin
            failures++;
            $display("FAIL odd_lock_latency got=%0d exp=17", first - 9);
        end
        for (int i = 0; i < 25; i++) begin
            tick(1, 1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL odd_words t=%0t got=%h exp=%h", $time, obs(), expv());
            end
            if (word_valid === 1'b1) begin
                checks++;
                if (!kc(word_out) || is_comma !== 1'b1 || (nv > 0 && word_out === prev)) begin
                    failures++;
                    $display("FAIL odd_alternate word=%b prev=%b exp alternating K28.5", word_out, prev);
                end
                prev = word_out;
                nv++;
            end
        end
        checks++;
        if (nv != 5) begin
            failures++;
            $display("FAIL odd_word_rate got=%0d exp=5", nv);
        end
    endtask

    task automatic test_data();
        int nd = 0;
        repeat (8) push_word(D215);
        for (int i = 0; i < 60; i++) begin
            tick(1, 1);
            checks++;
            if (obs() !== expv() || locked !== 1'b1) begin
                failures++;
                $display("FAIL data_track t=%0t got=%h exp=%h", $time, obs(), expv());
            end
            if (word_valid === 1'b1 && word_out === D215) begin
                nd++;
                checks++;
                if (is_comma !== 1'b0) begin
                    failures++;
                    $display("FAIL data_is_comma got=%b exp=0", is_comma);
                end
            end
        end
        checks++;
        if (nd != 8) begin
            failures++;
            $display("FAIL data_words got=%0d exp=8", nd);
        end
    endtask

    task automatic test_slip();
        bit dropped = 0;
        int t = 0;
        do_reset();
        push_zeros(10);
        push_k(8);
        while (locked !== 1'b1 && t < 60) begin
            tick(1, 1);
            t++;
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL slip_lock t=%0t got=%h exp=%h", $time, obs(), expv());
            end
        end
        push_zeros(2);
        push_k(16);
        for (int i = 0; i < 120; i++) begin
            tick(1, 1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL slip_track t=%0t got=%h exp=%h", $time, obs(), expv());
            end
            if (locked === 1'b0) dropped = 1;
        end
        checks++;
        if (!dropped || realign_cnt !== 8'd1 || locked !== 1'b1) begin
            failures++;
            $display("FAIL slip_relock dropped=%0d realign=%0d locked=%b exp 1/1/1", dropped, realign_cnt, locked);
        end
    endtask

    task automatic test_verify_fail();
        bit any_lock = 0;
        do_reset();
        push_zeros(10);
        push_k(2);
        repeat (3) push_word(D215);
        push_zeros(20);
        for (int i = 0; i < 50; i++) begin
            tick(1, 1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL verify_track t=%0t got=%h exp=%h", $time, obs(), expv());
            end
            if (locked !== 1'b0) any_lock = 1;
        end
        checks++;
        if (any_lock) begin
            failures++;
            $display("FAIL verify_no_lock got=1 exp=0");
        end
        push_k(6);
        for (int i = 0; i < 50; i++) begin
            tick(1, 1);
            checks++;
            if (obs() !== expv()) begin
                failures++;
                $display("FAIL verify_retry t=%0t got=%h exp=%h", $time, obs(), expv());
            end
        end
        checks++;
        if (realign_cnt !== 8'd0 || m_mode != 2 || locked !== 1'b1) begin
            failures++;
            $display("FAIL verify_relock locked=%b exp=1", locked);
        end
    endtask

    task automatic test_reset_en();
        int dn = 0;
        int mn = 0;
        int gap;
        do_reset();
        push_zeros(10);
        push_k(20);
        repeat (32) tick(1, 1);
        tick(0, 1);
        checks++;
        if (obs() !== 21'h0) begin
            failures++;
            $display("FAIL midword_reset got=%h exp=%h", obs(), 21'h0);
        end
        txq.delete();
        rd = 0;
        push_zeros(10);
        push_k(30);
        repeat (30) tick(1, 1);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL en_prelock got=%b exp=1", locked);
        end
        gap = $urandom_range(5, 9);
        for (int i = 0; i < 80; i++) begin
            bit e = !(i >= gap && i < gap + 7);
            tick(1, e);
            checks++;
            if (obs() !== expv() || (!e && word_valid !== 1'b0)) begin
                failures++;
                $display("FAIL en_gap t=%0t en=%b got=%h exp=%h", $time, e, obs(), expv());
            end
            if (word_valid === 1'b1) dn++;
            if (m_vq && e) mn++;
        end
        checks++;
        if (dn != mn || mn < 14 || realign_cnt !== 8'd0 || locked !== 1'b1) begin
            failures++;
            $display("FAIL en_no_loss words=%0d exp=%0d realign=%0d locked=%b", dn, mn, realign_cnt, locked);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < 500; i++) begin
                if (txq.size() < 20) begin
                    int sel = $urandom_range(0, 9);
                    if (sel < 6) push_k(1);
                    else if (sel < 8) push_word(D215);
                    else if (sel == 8) push_word(10'($urandom));
                    else repeat ($urandom_range(1, 3)) txq.push_back(1'($urandom));
                end
                tick(1, $urandom_range(0, 9) != 0);
                checks++;
                if (obs() !== expv()) begin
                    failures++;
                    $display("FAIL random_track t=%0t got=%h exp=%h", $time, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_even();
        test_lock_odd();
        test_data();
        test_slip();
        test_verify_fail();
        test_reset_en();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
